// File: rtl/timer_arbiter.sv
// Round-robin arbiter sharing one prescaled countdown timer among NREQ requesters.
// Optional ABORT input is enabled by defining TIMER_ABORT_EN.
module timer_arbiter #(
  parameter int NREQ     = 4,
  parameter int DW       = 16,
  parameter int PRESCALE = 100,
  localparam int GW      = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [NREQ-1:0]    REQ,
  input  logic [NREQ*DW-1:0] DLY,
`ifdef TIMER_ABORT_EN
  input  logic               ABORT,
`endif
  output logic [NREQ-1:0]    ACK,
  output logic [NREQ-1:0]    DONE,
  output logic               BUSY,
  output logic [GW-1:0]      GNT_ID
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t          state;
  logic [GW-1:0]   rr_ptr;
  logic [PW-1:0]   pcnt;
  logic [DW-1:0]   remaining;
  logic            found;
  logic [GW-1:0]   pick_idx;
  logic [DW-1:0]   pick_dly;
  logic            abort_now;
  int              idx;

`ifdef TIMER_ABORT_EN
  assign abort_now = ABORT;
`else
  assign abort_now = 1'b0;
`endif

  // First requester at or above rr_ptr, wrapping around.
  always_comb begin
    found    = 1'b0;
    pick_idx = '0;
    idx      = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(rr_ptr) + k) % NREQ;
      if (!found && REQ[GW'(idx)]) begin
        found    = 1'b1;
        pick_idx = GW'(idx);
      end
    end
  end

  assign pick_dly = DLY[int'(pick_idx)*DW +: DW];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      ACK       <= '0;
      DONE      <= '0;
      BUSY      <= 1'b0;
      GNT_ID    <= '0;
      rr_ptr    <= '0;
      pcnt      <= '0;
      remaining <= '0;
    end else begin
      ACK  <= '0;
      DONE <= '0;
      case (state)
        IDLE: begin
          if (found) begin
            remaining <= pick_dly;
            pcnt      <= '0;
            GNT_ID    <= pick_idx;
            rr_ptr    <= (pick_idx == GW'(NREQ-1)) ? '0 : pick_idx + GW'(1);
            ACK       <= NREQ'(1) << pick_idx;
            BUSY      <= 1'b1;
            state     <= RUN;
          end
        end
        RUN: begin
          if (abort_now) begin
            state <= IDLE;
            BUSY  <= 1'b0;
            pcnt  <= '0;
          end else if (remaining == '0) begin
            // Zero-length delay: one RUN cycle keeps ACK and DONE in separate cycles.
            state <= FIN;
            DONE  <= NREQ'(1) << GNT_ID;
          end else if (pcnt == PW'(PRESCALE-1)) begin
            pcnt      <= '0;
            remaining <= remaining - DW'(1);
            if (remaining == DW'(1)) begin
              state <= FIN;
              DONE  <= NREQ'(1) << GNT_ID;
            end
          end else begin
            pcnt <= pcnt + PW'(1);
          end
        end
        FIN: begin
          state <= IDLE;
          BUSY  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          BUSY  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_timer_arbiter.sv
// Randomized scoreboard bench for timer_arbiter (NREQ=4, DW=8, PRESCALE=4).
module tb_timer_arbiter;

  localparam int NREQ     = 4;
  localparam int DW       = 8;
  localparam int PRESCALE = 4;

  typedef struct {
    bit is_done;
    int id;
    int cyc;
  } ev_t;

  logic              clk;
  logic              rst;
  logic [NREQ-1:0]   req;
  logic [NREQ*DW-1:0] dly_bus;
  logic [NREQ-1:0]   ack;
  logic [NREQ-1:0]   done;
  logic              busy;
  logic [1:0]        gnt_id;
`ifdef TIMER_ABORT_EN
  logic              abort;
`endif

  logic [DW-1:0] dly_m [NREQ];
  ev_t           sb [$];
  int            cyc;
  int            idle_at;
  int            rr_m;
  int            n_checks;
  int            n_fail;
  bit            exp_busy;
  bit            saw_done;
  ev_t           e;

  assign dly_bus = {dly_m[3], dly_m[2], dly_m[1], dly_m[0]};

  timer_arbiter #(.NREQ(NREQ), .DW(DW), .PRESCALE(PRESCALE)) dut (
    .CLK   (clk),
    .RST   (rst),
    .REQ   (req),
    .DLY   (dly_bus),
`ifdef TIMER_ABORT_EN
    .ABORT (abort),
`endif
    .ACK   (ack),
    .DONE  (done),
    .BUSY  (busy),
    .GNT_ID(gnt_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", nm, cyc, got, exp);
    end
  endtask

  // Monitor: pops expected events whenever the DUT pulses ACK or DONE.
  initial begin
    exp_busy = 1'b0;
    saw_done = 1'b0;
  end
  always @(negedge clk) begin
    if (rst) begin
      exp_busy = 1'b0;
      check("busy_in_reset", int'(busy), 0);
    end else begin
      saw_done = 1'b0;
      if (done != '0) begin
        saw_done = 1'b1;
        if (sb.size() == 0) begin
          check("unexpected_done", int'(done), 0);
        end else begin
          e = sb.pop_front();
          check("done_vec", int'(done), e.is_done ? (1 << e.id) : 0);
          check("done_cycle", cyc, e.cyc);
          check("gnt_id_at_done", int'(gnt_id), e.id);
        end
      end
      if (ack != '0) begin
        if (sb.size() == 0) begin
          check("unexpected_ack", int'(ack), 0);
        end else begin
          e = sb.pop_front();
          check("ack_vec", int'(ack), e.is_done ? 0 : (1 << e.id));
          check("ack_cycle", cyc, e.cyc);
          check("gnt_id_at_ack", int'(gnt_id), e.id);
          exp_busy = 1'b1;
        end
      end
      check("busy", int'(busy), int'(exp_busy));
      if (saw_done) exp_busy = 1'b0;
    end
  end

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  function automatic int next_winner(input logic [NREQ-1:0] pend, input int rr);
    for (int k = 0; k < NREQ; k++) begin
      if (pend[(rr + k) % NREQ]) return (rr + k) % NREQ;
    end
    return -1;
  endfunction

  function automatic logic [DW-1:0] rand_dly();
    if ($urandom_range(0, 99) < 10) return '0;
    return DW'($urandom_range(1, 6));
  endfunction

  // Drive a burst of requests; the model predicts every grant from the round-robin rule.
  task automatic run_burst(input logic [NREQ-1:0] mask0, input bit hold,
                           input int max_grants, input int ext_pct);
    logic [NREQ-1:0] pending;
    logic [NREQ-1:0] extra;
    int g, w, d, ackc, donec, t, grants;
    pending = mask0;
    g = (cyc + 1 > idle_at) ? cyc + 1 : idle_at;
    wait_until(g);
    req = pending;
    grants = 0;
    while (pending != '0 && grants < max_grants) begin
      w     = next_winner(pending, rr_m);
      d     = int'(dly_m[w]);
      ackc  = g + 1;
      donec = ackc + ((d == 0) ? 1 : d * PRESCALE);
      sb.push_back('{1'b0, w, ackc});
      sb.push_back('{1'b1, w, donec});
      rr_m = (w + 1) % NREQ;
      grants++;
      if (!hold) pending[w] = 1'b0;
      if (grants < max_grants && $urandom_range(0, 99) < ext_pct) begin
        extra = NREQ'($urandom_range(1, 15)) & ~pending;
        extra[w] = 1'b0;
        if (extra != '0) begin
          t = $urandom_range(ackc, donec);
          wait_until(t);
          for (int i = 0; i < NREQ; i++) if (extra[i]) dly_m[i] = rand_dly();
          pending = pending | extra;
          req = pending;
        end
      end
      wait_until(donec);
      if (grants >= max_grants) pending = '0;
      req = pending;
      idle_at = donec + 1;
      g = donec + 1;
    end
  endtask

  initial begin
    #(10 * 80000);
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int c, w;
    n_checks = 0;
    n_fail   = 0;
    rr_m     = 0;
    rst      = 1'b1;
    req      = '0;
`ifdef TIMER_ABORT_EN
    abort    = 1'b0;
`endif
    for (int i = 0; i < NREQ; i++) dly_m[i] = '0;
    #1;
    check("reset_ack", int'(ack), 0);
    check("reset_done", int'(done), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_gnt_id", int'(gnt_id), 0);
    @(negedge clk);
    #1 rst = 1'b0;
    idle_at = cyc + 1;

    // All four held with one-tick delays: grants rotate 0,1,2,3,0.
    for (int i = 0; i < NREQ; i++) dly_m[i] = 8'd1;
    run_burst(4'b1111, 1'b1, 5, 0);
    // Single requester, 3 ticks: DONE 12 cycles after ACK.
    dly_m[0] = 8'd3;
    run_burst(4'b0001, 1'b0, 1, 0);
    // Zero delay: DONE the cycle after ACK.
    dly_m[2] = 8'd0;
    run_burst(4'b0100, 1'b0, 1, 0);
    // Late requests during RUN wait for the current DONE.
    dly_m[0] = 8'd2;
    run_burst(4'b0001, 1'b0, 3, 100);
    // Largest delay the counter can hold.
    dly_m[3] = 8'hFF;
    run_burst(4'b1000, 1'b0, 1, 0);

    repeat (40) begin
      for (int i = 0; i < NREQ; i++) dly_m[i] = rand_dly();
      run_burst(NREQ'($urandom_range(1, 15)), 1'($urandom_range(0, 1)),
                $urandom_range(1, 6), 50);
    end

    // Reset in the middle of a 5-tick delay: no DONE, pointer back to 0.
    c = (cyc + 1 > idle_at) ? cyc + 1 : idle_at;
    wait_until(c);
    dly_m[1] = 8'd5;
    req = 4'b0010;
    w = next_winner(4'b0010, rr_m);
    sb.push_back('{1'b0, w, c + 1});
    wait_until(c + 8);
    req = '0;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrun_reset_ack", int'(ack), 0);
    check("midrun_reset_done", int'(done), 0);
    check("midrun_reset_busy", int'(busy), 0);
    check("midrun_reset_gnt_id", int'(gnt_id), 0);
    @(negedge clk);
    #1 rst = 1'b0;
    rr_m = 0;
    idle_at = cyc + 1;
    dly_m[1] = 8'd2;
    dly_m[3] = 8'd2;
    run_burst(4'b1010, 1'b0, 2, 0);

    repeat (8) begin
      for (int i = 0; i < NREQ; i++) dly_m[i] = rand_dly();
      run_burst(NREQ'($urandom_range(1, 15)), 1'($urandom_range(0, 1)),
                $urandom_range(1, 5), 50);
    end

    wait_until(idle_at + 4);
    check("scoreboard_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
